// File: rtl/wb_src_pkg.sv
// Shared types and constants for the register-file write-back source selector.
package wb_src_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_NUM_SRC = 10;

    localparam int SRC_ALUOUT   = 0;
    localparam int SRC_SLS      = 1;
    localparam int SRC_LO       = 2;
    localparam int SRC_HI       = 3;
    localparam int SRC_SHIFTREG = 4;
    localparam int SRC_LT       = 5;
    localparam int SRC_SIGNEXT  = 6;
    localparam int SRC_SHL16    = 7;
    localparam int SRC_REGA     = 8;
    localparam int SRC_REGB     = 9;

    // A single-source mux still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_src_timer.sv
// Saturating WAIT-state cycle counter; expired marks the last permitted wait cycle.
module wb_src_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of wait cycles already completed before this edge
    assign expired = en && (count >= CNT_LAST);

endmodule

// File: rtl/writeback_source_mux.sv
// Registered write-back source selector that waits for the chosen source to be ready.
// Optional timeout abort of the WAIT state is built when WB_SRC_TIMEOUT_EN is defined.
module writeback_source_mux
    import wb_src_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int NUM_SRC        = DEFAULT_NUM_SRC,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int SEL_W         = sel_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [SEL_W-1:0]          req_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic [SEL_W-1:0]          wb_sel,
    output logic                      wb_valid,
    output logic                      busy,
    output logic                      err
);

    localparam int                 PAD_N     = 2 ** SEL_W;
    localparam logic [SEL_W:0]     NUM_SRC_L = NUM_SRC[SEL_W:0];

    state_t             state;
    logic [SEL_W-1:0]   wait_sel;
    logic [SEL_W-1:0]   cur_sel;
    logic [DATA_W-1:0]  chan [PAD_N];
    logic [PAD_N-1:0]   rdy_pad;
    logic [DATA_W-1:0]  cur_data;
    logic               cur_ready;
    logic               sel_legal;
    logic               timeout_hit;

    // Pad sources to a power of two so any select value indexes safely.
    for (genvar k = 0; k < PAD_N; k++) begin : g_chan
        if (k < NUM_SRC) begin : g_real
            assign chan[k]    = src_data[k*DATA_W +: DATA_W];
            assign rdy_pad[k] = src_ready[k];
        end else begin : g_pad
            assign chan[k]    = '0;
            assign rdy_pad[k] = 1'b0;
        end
    end

    assign cur_sel   = (state == ST_IDLE) ? req_sel : wait_sel;
    assign cur_data  = chan[cur_sel];
    assign cur_ready = rdy_pad[cur_sel];
    assign sel_legal = ({1'b0, req_sel} < NUM_SRC_L);

`ifdef WB_SRC_TIMEOUT_EN
    wb_src_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == ST_IDLE),
        .en      (state == ST_WAIT),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_sel <= '0;
            wb_data  <= '0;
            wb_sel   <= '0;
            wb_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!sel_legal) begin
                            err <= 1'b1;
                        end else if (cur_ready) begin
                            wb_data  <= cur_data;
                            wb_sel   <= req_sel;
                            wb_valid <= 1'b1;
                        end else begin
                            wait_sel <= req_sel;
                            state    <= ST_WAIT;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ready takes priority over a timeout expiring on the same edge.
                    if (cur_ready) begin
                        wb_data  <= cur_data;
                        wb_sel   <= wait_sel;
                        wb_valid <= 1'b1;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_source_mux.sv
// Scoreboard bench for writeback_source_mux: default 10x32 instance plus a 3x16 instance.
module tb_writeback_source_mux;

    localparam int DW = 32;
    localparam int NS = 10;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              req_valid;
    logic [SW-1:0]     req_sel;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic [DW-1:0]     wb_data;
    logic [SW-1:0]     wb_sel;
    logic              wb_valid;
    logic              busy;
    logic              err;

    logic              req_valid_s;
    logic [1:0]        req_sel_s;
    logic [47:0]       src_data_s;
    logic [2:0]        src_ready_s;
    logic [15:0]       wb_data_s;
    logic [1:0]        wb_sel_s;
    logic              wb_valid_s;
    logic              busy_s;
    logic              err_s;

    int tests = 0;
    int fails = 0;
    logic [SW+DW-1:0] exp_q [$];

    writeback_source_mux #(
        .DATA_W         (DW),
        .NUM_SRC        (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .src_data  (src_data),
        .src_ready (src_ready),
        .wb_data   (wb_data),
        .wb_sel    (wb_sel),
        .wb_valid  (wb_valid),
        .busy      (busy),
        .err       (err)
    );

    writeback_source_mux #(
        .DATA_W  (16),
        .NUM_SRC (3)
    ) dut_small (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_s),
        .req_sel   (req_sel_s),
        .src_data  (src_data_s),
        .src_ready (src_ready_s),
        .wb_data   (wb_data_s),
        .wb_sel    (wb_sel_s),
        .wb_valid  (wb_valid_s),
        .busy      (busy_s),
        .err       (err_s)
    );

    // Scoreboard: every wb_valid pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (wb_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: wb_valid with sel=%0d data=%h, expected no pulse", wb_sel, wb_data);
            end else begin
                logic [SW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({wb_sel, wb_data} !== e)
                begin
                    fails++;
                    $display("FAIL sb_capture: got sel=%0d data=%h, expected sel=%0d data=%h",
                             wb_sel, wb_data, e[SW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (wb_valid && err) begin
            tests++;
            fails++;
            $display("FAIL excl_pulse: wb_valid=1 err=1, expected never both");
        end
    end

    task automatic set_chan(input int k, input logic [DW-1:0] v);
        src_data[k*DW +: DW] = v;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        req_valid   = 1'b1;
        req_sel     = '0;
        src_ready   = '1;
        src_data    = '1;
        req_valid_s = 1'b1;
        req_sel_s   = 2'd0;
        src_ready_s = '1;
        src_data_s  = '1;
        repeat (2) @(negedge clk);
        tests++;
        if ({wb_data, wb_sel, wb_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_vals: got data=%h sel=%0d v=%b b=%b e=%b, expected all 0",
                     wb_data, wb_sel, wb_valid, busy, err);
        end
        tests++;
        if ({wb_data_s, wb_sel_s, wb_valid_s, busy_s, err_s} !== '0) begin
            fails++;
            $display("FAIL reset_small: got data=%h sel=%0d, expected 0", wb_data_s, wb_sel_s);
        end
        req_valid   = 1'b0;
        req_valid_s = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        tests++;
        if ({wb_data, wb_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_idle: got data=%h v=%b b=%b e=%b, expected 0", wb_data, wb_valid, busy, err);
        end
    endtask

    task automatic test_capture_ready;
        set_chan(0, 32'h1234_5678);
        src_ready = '1;
        req_sel   = 4'd0;
        req_valid = 1'b1;
        exp_q.push_back({4'd0, 32'h1234_5678});
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL imm_capture: got v=%b data=%h, expected v=1 data=12345678", wb_valid, wb_data);
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL imm_pulse_width: got v=%b, expected 0", wb_valid);
        end
        set_chan(0, 32'h0BAD_F00D);
        @(negedge clk);
        tests++;
        if (wb_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL data_hold: got %h, expected 12345678", wb_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d [NS];
        for (int k = 0; k < NS; k++) begin
            d[k] = $urandom;
            set_chan(k, d[k]);
        end
        src_ready = '1;
        req_valid = 1'b1;
        for (int k = 0; k < NS; k++) begin
            req_sel = SW'(NS - 1 - k);
            exp_q.push_back({SW'(NS - 1 - k), d[NS - 1 - k]});
            @(negedge clk);
            tests++;
            if (wb_valid !== 1'b1 || wb_sel !== SW'(NS - 1 - k)) begin
                fails++;
                $display("FAIL b2b_ch%0d: got v=%b sel=%0d, expected v=1 sel=%0d", NS - 1 - k, wb_valid, wb_sel, NS - 1 - k);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_ready;
        set_chan(3, 32'hDEAD_BEEF);
        set_chan(0, 32'h5555_AAAA);
        src_ready    = '1;
        src_ready[3] = 1'b0;
        req_sel      = 4'd3;
        req_valid    = 1'b1;
        exp_q.push_back({4'd3, 32'hDEAD_BEEF});
        @(negedge clk);
        req_sel = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (busy !== 1'b1 || wb_valid !== 1'b0) begin
                fails++;
                $display("FAIL wait_busy_%0d: got b=%b v=%b, expected b=1 v=0", i, busy, wb_valid);
            end
            if (i == 4) begin
                src_ready[3] = 1'b1;
                req_valid    = 1'b0;
            end
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_sel !== 4'd3) begin
            fails++;
            $display("FAIL wait_capture: got b=%b v=%b sel=%0d data=%h, expected b=0 v=1 sel=3 data=deadbeef",
                     busy, wb_valid, wb_sel, wb_data);
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL wait_pulse_width: got v=%b, expected 0", wb_valid);
        end
    endtask

    task automatic test_illegal_sel;
        logic [DW-1:0] prev;
        logic [SW-1:0] bad [3];
        prev   = wb_data;
        bad[0] = 4'd12;
        bad[1] = 4'd10;
        bad[2] = 4'd15;
        src_ready = '1;
        for (int i = 0; i < 3; i++) begin
            req_sel   = bad[i];
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            tests++;
            if (err !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== prev) begin
                fails++;
                $display("FAIL illegal_sel%0d: got e=%b b=%b v=%b data=%h, expected e=1 b=0 v=0 data=%h",
                         bad[i], err, busy, wb_valid, wb_data, prev);
            end
            @(negedge clk);
            tests++;
            if (err !== 1'b0) begin
                fails++;
                $display("FAIL illegal_pulse%0d: got e=%b, expected 0", bad[i], err);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        src_ready    = '1;
        src_ready[5] = 1'b0;
        req_sel      = 4'd5;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_wait_busy: got b=%b, expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({wb_data, wb_sel, wb_valid, busy, err} !== '0) begin
            fails++;
            $display("FAIL rst_async: got data=%h sel=%0d v=%b b=%b e=%b, expected all 0",
                     wb_data, wb_sel, wb_valid, busy, err);
        end
        src_ready[5] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (wb_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL rst_after: got v=%b b=%b e=%b, expected 0", wb_valid, busy, err);
            end
        end
    endtask

`ifdef WB_SRC_TIMEOUT_EN
    task automatic test_timeout;
        logic [DW-1:0] prev;
        prev         = wb_data;
        set_chan(2, 32'hCAFE_0002);
        src_ready    = '1;
        src_ready[2] = 1'b0;
        req_sel      = 4'd2;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tests++;
            if (busy !== 1'b1 || err !== 1'b0) begin
                fails++;
                $display("FAIL to_wait_%0d: got b=%b e=%b, expected b=1 e=0", i, busy, err);
            end
            @(negedge clk);
        end
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== prev) begin
            fails++;
            $display("FAIL to_expire: got e=%b b=%b v=%b data=%h, expected e=1 b=0 v=0 data=%h",
                     err, busy, wb_valid, wb_data, prev);
        end
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) begin
                src_ready[2] = 1'b1;
                exp_q.push_back({4'd2, 32'hCAFE_0002});
            end
            @(negedge clk);
        end
        tests++;
        if (wb_valid !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL to_ready_tie: got v=%b e=%b b=%b, expected v=1 e=0 b=0", wb_valid, err, busy);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_small_config;
        src_data_s  = {16'hA5A5, 16'h1111, 16'h2222};
        src_ready_s = 3'b111;
        req_sel_s   = 2'd2;
        req_valid_s = 1'b1;
        @(negedge clk);
        req_valid_s = 1'b0;
        tests++;
        if (wb_valid_s !== 1'b1 || wb_data_s !== 16'hA5A5 || wb_sel_s !== 2'd2) begin
            fails++;
            $display("FAIL small_capture: got v=%b sel=%0d data=%h, expected v=1 sel=2 data=a5a5",
                     wb_valid_s, wb_sel_s, wb_data_s);
        end
        req_sel_s   = 2'd3;
        req_valid_s = 1'b1;
        @(negedge clk);
        req_valid_s = 1'b0;
        tests++;
        if (err_s !== 1'b1 || wb_valid_s !== 1'b0 || wb_data_s !== 16'hA5A5) begin
            fails++;
            $display("FAIL small_illegal: got e=%b v=%b data=%h, expected e=1 v=0 data=a5a5",
                     err_s, wb_valid_s, wb_data_s);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_capture_ready();
        test_back_to_back();
        test_wait_ready();
        test_illegal_sel();
        test_reset_mid_wait();
`ifdef WB_SRC_TIMEOUT_EN
        test_timeout();
`endif
        test_small_config();
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d captures never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
